lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller that sits between the core's execute stage and the word-addressed data memory. Accepts one byte/half/word load or store per request, drives the memory's word-wide `addr`/`wdata`/`we` port, and returns sign- or zero-extended load data. Memory has 1-cycle synchronous read and whole-word writes only. Sub-word stores are therefore done as read-modify-write.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; fixed at 32, because lane logic assumes 4 bytes.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: core request present.
- `req_ready` out 1: high only in IDLE. A request is accepted on a rising edge with `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned` in 1: loads are zero-extended when high, sign-extended when low.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle pulse, no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `resp_err` out 1: misaligned-access flag, valid with `resp_valid`.
- `mem_addr` out 32: word-aligned `{req_addr[31:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `mem_we` out 1: memory write enable.
- `mem_rdata` in 32: memory read data, valid the cycle after the address is presented with `mem_we=0`.

## Operation
- States: IDLE, READ, CAPTURE, MERGE, WRITE, RESP.
- All outputs are registered and updated on state-transition edges.
- Request is latched on the accept edge. Next state after accept:
  - Load → READ
  - Word store → WRITE
  - Sub-word store → READ, with the RMW flag set
  - Misaligned access (see Configuration) → RESP
- READ: drive `mem_addr`, `mem_we=0`. Go to CAPTURE for a load, MERGE for RMW.
- CAPTURE: select the lane from `mem_rdata`, extend it, and register into `resp_rdata`. Go to RESP.
  - Byte: lane `addr[1:0]`, bits `[8*lane+7:8*lane]`.
  - Half: `addr[1]` selects `[15:0]` or `[31:16]`.
  - Extension: sign-extend from bit 7/15 unless `req_unsigned`.
- MERGE: replace the addressed byte/half of `mem_rdata` with the low bits of the latched wdata and register the result into `mem_wdata`. Go to WRITE.
- WRITE: `mem_we=1` for exactly one cycle. Go to RESP.
- RESP: `resp_valid=1` for one cycle, then IDLE.
  - `mem_we` is 0 in every state except WRITE.
  - `mem_addr` holds its last value.
- New requests are never accepted outside IDLE. There is no overlap between transactions.
- Reset values: state IDLE; `req_ready=1` after reset is released; `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_addr=0`, `mem_wdata=0`, `mem_we=0`.
- Reset mid-operation: the transaction is dropped, no response is issued, and outputs take reset values at that edge.
  - If `rst` coincides with WRITE, the memory's own reset priority suppresses the write.

## Timing
Cycle 0 is the accept edge; latencies count to the edge that ends the cycle where `resp_valid` is high.
- Misaligned: `resp_valid` in cycle 1; no memory access.
- Word store: WRITE in cycle 1 (memory commits at edge 2); `resp_valid` in cycle 2.
- Load: READ cycle 1, CAPTURE cycle 2, `resp_valid` cycle 3.
- Sub-word store: READ 1, MERGE 2, WRITE 3, `resp_valid` cycle 4.
- `req_ready` returns high the cycle after RESP.
- Minimum issue spacing:
  - 2 cycles for misaligned
  - 3 cycles for a word store
  - 4 cycles for a load
  - 5 cycles for a sub-word store

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned means half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - A misaligned request goes straight to RESP with `resp_err=1` and `resp_rdata=0`. Memory is untouched.
- Not defined:
  - No alignment check. Half uses `addr[1]` and ignores `addr[0]`; word ignores `addr[1:0]`.
  - `resp_err` is tied to 0.

## Test plan
- Reset, then word store 0xDEADBEEF @0x10, then load word @0x10 → `mem_we` high for exactly 1 cycle, `resp_rdata=0xDEADBEEF`, load `resp_valid` 3 cycles after accept.
- Word @0x20 = 0x11223344. Store byte 0xAA @0x22 → memory word 0x11AA3344. Load byte signed @0x22 → 0xFFFFFFAA. Load unsigned @0x22 → 0x000000AA.
- Store half 0x8001 @0x20 → word 0x11AA8001. Load half signed @0x20 → 0xFFFF8001. Load half @0x22 → 0x000011AA.
- With `LSU_MISALIGN_TRAP_EN`: load word @0x21 → `resp_err=1`, `resp_rdata=0`, `resp_valid` in cycle 1, `mem_we` never high. Without the macro: same access returns the word @0x20 with `resp_err=0`.
- `req_valid` held high continuously → `req_ready` high only in IDLE, exactly one accept per transaction, `resp_valid` pulses never back-to-back.
- `rst` asserted during MERGE of a byte store → no write reaches memory, no `resp_valid`, all outputs at reset values the next cycle, and the next request completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the execute stage and a word-addressed
// data memory (1-cycle synchronous read, whole-word write). Sub-word stores are
// performed as read-modify-write; loads are lane-selected and sign/zero-extended.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake (ready only while idle)
//   req_we, req_size,        - store flag, size (00 byte, 01 half, 1x word),
//   req_unsigned             - zero-extend loads when high
//   req_addr, req_wdata      - byte address, right-aligned store data
//   resp_valid               - one-cycle response pulse, no backpressure
//   resp_rdata, resp_err     - extended load data (0 for stores), misaligned flag
//   mem_addr, mem_wdata,     - word-aligned memory address, full write word,
//   mem_we, mem_rdata        - write enable, read data (valid one cycle after addr)
//
// Build option: LSU_MISALIGN_TRAP_EN enables the alignment check; misaligned
// accesses then respond immediately with resp_err=1 and never touch memory.
// Without it, half ignores addr[0], word ignores addr[1:0], and resp_err stays 0.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StCapture, StMerge, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  // Request fields latched on the accept edge.
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        rmw_q;

  logic        accept;
  logic        misalign;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  assign accept = req_valid && ready_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Load lane select and extension.
  always_comb begin
    rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // RMW merge; only reached for byte or half stores.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ready_d      = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (misalign) begin
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else begin
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we && req_size[1]) begin
              mem_wdata_d = req_wdata;
              mem_we_d    = 1'b1;
              state_d     = StWrite;
            end else begin
              state_d = StRead;
            end
          end
        end
      end
      StRead:    state_d = rmw_q ? StMerge : StCapture;
      StCapture: begin
        resp_rdata_d = load_ext;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StMerge: begin
        mem_wdata_d = merged;
        mem_we_d    = 1'b1;
        state_d     = StWrite;
      end
      StWrite: begin
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      rmw_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      if (state_q == StIdle && accept) begin
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
        rmw_q   <= req_we && !req_size[1];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: behavioural word memory, response scoreboard, directed steps.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  // Memory model: synchronous read, whole-word write, reset blocks the write.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  int n_chk = 0;
  int n_err = 0;
  int resp_cnt = 0;
  logic [32:0] sb [$];  // {err, rdata}
  logic prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each resp_valid pulse.
  always @(negedge clk) begin
    logic [32:0] e;
    if (resp_valid) begin
      resp_cnt++;
      chk("resp_not_back_to_back", {31'd0, prev_rv}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e[31:0]);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
    prev_rv = resp_valid;
  end

  // Issue one request, then measure response latency and write-enable cycles.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_we);
    int cyc;
    int wecnt;
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    sb.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; wecnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_we) wecnt++;
    end while (!resp_valid && cyc < 20);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_we_cycles"}, wecnt, exp_we);
  endtask

  initial begin
    int acc;
    int rc0;
    int wecnt;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);

    issue("st_w_10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1);
    chk("mem_10", mem[4], 32'hDEADBEEF);
    issue("ld_w_10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0);
    issue("st_w_20", 1, 2'b11, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 1);
    issue("st_b_22", 1, 2'b00, 0, 32'h22, 32'hFFFFFFAA, 32'h0, 0, 4, 1);
    chk("mem_20_b", mem[8], 32'h11AA3344);
    issue("ld_b_s_22", 0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFFAA, 0, 3, 0);
    issue("ld_b_u_22", 0, 2'b00, 1, 32'h22, 32'h0, 32'h000000AA, 0, 3, 0);
    issue("st_h_20", 1, 2'b01, 0, 32'h20, 32'h00008001, 32'h0, 0, 4, 1);
    chk("mem_20_h", mem[8], 32'h11AA8001);
    issue("ld_h_s_20", 0, 2'b01, 0, 32'h20, 32'h0, 32'hFFFF8001, 0, 3, 0);
    issue("ld_h_s_22", 0, 2'b01, 0, 32'h22, 32'h0, 32'h000011AA, 0, 3, 0);
    issue("ld_h_u_20", 0, 2'b01, 1, 32'h20, 32'h0, 32'h00008001, 0, 3, 0);
    issue("ld_b_u_23", 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000011, 0, 3, 0);
    issue("st_b_21", 1, 2'b00, 0, 32'h21, 32'h5A5A5A7F, 32'h0, 0, 4, 1);
    chk("mem_20_b1", mem[8], 32'h11AA7F01);
    issue("ld_b_s_21", 0, 2'b00, 0, 32'h21, 32'h0, 32'h0000007F, 0, 3, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue("ld_w_21", 0, 2'b10, 0, 32'h21, 32'h0, 32'h0, 1, 1, 0);
    issue("st_h_23", 1, 2'b01, 0, 32'h23, 32'h0000BEEF, 32'h0, 1, 1, 0);
    chk("mem_20_untouched", mem[8], 32'h11AA7F01);
`else
    issue("ld_w_21", 0, 2'b10, 0, 32'h21, 32'h0, 32'h11AA7F01, 0, 3, 0);
`endif

    // req_valid held high: one accept per 4-cycle load, no overlap.
    repeat (2) @(negedge clk);
    repeat (4) sb.push_back({1'b0, 32'hDEADBEEF});
    rc0 = resp_cnt; acc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10;
    repeat (16) begin
      @(posedge clk);
      if (req_valid && req_ready) acc++;
    end
    #1 req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("cont_accepts", acc, 4);
    chk("cont_resps", resp_cnt - rc0, 4);

    // Reset during MERGE of a byte store: no write, no response.
    @(negedge clk);
    rc0 = resp_cnt; wecnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);  // READ
    if (mem_we) wecnt++;
    @(negedge clk);  // MERGE
    if (mem_we) wecnt++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mr_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mr_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mr_mem_addr", mem_addr, 32'd0);
    chk("mr_mem_wdata", mem_wdata, 32'd0);
    chk("mr_resp_rdata", resp_rdata, 32'd0);
    repeat (5) begin
      @(negedge clk);
      if (mem_we) wecnt++;
    end
    chk("mr_we_cycles", wecnt, 0);
    chk("mr_no_resp", resp_cnt - rc0, 0);
    chk("mr_mem_10", mem[4], 32'hDEADBEEF);
    issue("post_rst_ld", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
